// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Bring-up sequence states.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } sup_state_e;

    // Width of a counter that must hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Multi-flop synchroniser for the raw PLL LOCK bits. Each bit has its own
// chain; the bits are independent, so there is no bus-coherence guarantee.
module lock_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the asynchronous LOCK bits through STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the chain is reset so locked reads a clean 0 after rst instead of stale or X history.
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises one or more PLLs from the reference clock: pulses PLL reset,
// qualifies the synchronised LOCK bits over a stable window, then releases
// sys_rst after a hold-off. Loss of lock re-runs the sequence; repeated
// lock timeouts end in a latched fault that only rst clears.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int CHANNELS        = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int STABLE_CYCLES   = 1024,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                                    clk_12m,
    input  logic                                    rst,
    input  logic [CHANNELS-1:0]                     lock_async,
    output logic [CHANNELS-1:0]                     pll_resetb,
    output logic [CHANNELS-1:0]                     locked,
    output logic                                    sys_rst,
    output logic                                    lost_lock,
    output logic                                    fault,
    output logic [cnt_width(MAX_RETRIES+1)-1:0]     retry_count
);

    localparam int RST_W = cnt_width(PLL_RST_CYCLES);
    localparam int STB_W = cnt_width(STABLE_CYCLES);
    localparam int HLD_W = cnt_width(RST_HOLD_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int RTY_W = cnt_width(MAX_RETRIES + 1);

    // Terminal count of each counter; every counter stops at its last value.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    sup_state_e       state;
    logic [RST_W-1:0] rst_cnt;
    logic [STB_W-1:0] stable_cnt;
    logic [HLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0] timeout_cnt;
    logic             pll_run;
    logic             all_locked;

    lock_sync #(
        .WIDTH  (CHANNELS),
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_12m),
        .rst (rst),
        .d   (lock_async),
        .q   (locked)
    );

    assign all_locked = &locked;

    // Every PLL sees the same registered reset.
    assign pll_resetb = {CHANNELS{pll_run}};

    // Bring-up sequencer. A counter is only ever non-zero inside the state
    // that owns it and is zeroed on the way out, so each state is entered
    // with its counters already at 0.
    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state       <= ST_RESET_PLL;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            hold_cnt    <= '0;
            timeout_cnt <= '0;
            pll_run     <= 1'b0;
            sys_rst     <= 1'b1;
            lost_lock   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads the pre-edge values and a later default cannot clobber an earlier test.
            lost_lock <= 1'b0;

            case (state)
                ST_RESET_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        rst_cnt <= '0;
                        pll_run <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (all_locked && stable_cnt == STB_LAST) begin
                        // Stable completion takes priority over a timeout in the same cycle.
                        state       <= ST_HOLD;
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                    end else if (timeout_cnt == TMO_LAST) begin
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                        pll_run     <= 1'b0;
                        if (retry_count < RTY_MAX) begin
                            state       <= ST_RESET_PLL;
                            retry_count <= retry_count + 1'b1;
                        end else begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        stable_cnt  <= all_locked ? stable_cnt + 1'b1 : '0;
                    end
                end

                ST_HOLD: begin
                    if (!all_locked) begin
                        // Not yet running, so this is a failed bring-up rather than a lost lock.
                        state    <= ST_RESET_PLL;
                        hold_cnt <= '0;
                        pll_run  <= 1'b0;
                    end else if (hold_cnt == HLD_LAST) begin
                        state       <= ST_RUN;
                        hold_cnt    <= '0;
                        sys_rst     <= 1'b0;
                        retry_count <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!all_locked) begin
                        state     <= ST_RESET_PLL;
                        pll_run   <= 1'b0;
                        sys_rst   <= 1'b1;
                        lost_lock <= 1'b1;
                    end
                end

                ST_FAULT: begin
                    // Terminal: outputs were set on entry and only rst leaves.
                end

                default: begin
                    // Unreachable encodings recover through a fresh PLL reset.
                    state       <= ST_RESET_PLL;
                    rst_cnt     <= '0;
                    stable_cnt  <= '0;
                    hold_cnt    <= '0;
                    timeout_cnt <= '0;
                    pll_run     <= 1'b0;
                    sys_rst     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: each stimulus step pushes the
// output values it implies, tagged with the cycle they must appear on; a
// monitor pops and compares them on the falling edge.
module tb_pll_lock_supervisor;

    localparam int CHANNELS        = 2;
    localparam int SYNC_STAGES     = 2;
    localparam int PLL_RST_CYCLES  = 3;
    localparam int STABLE_CYCLES   = 8;
    localparam int RST_HOLD_CYCLES = 4;
    localparam int TIMEOUT_CYCLES  = 32;
    localparam int MAX_RETRIES     = 2;
    localparam int QUAL            = STABLE_CYCLES + RST_HOLD_CYCLES;

    logic                clk_12m = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] lock_async;
    logic [CHANNELS-1:0] pll_resetb;
    logic [CHANNELS-1:0] locked;
    logic                sys_rst;
    logic                lost_lock;
    logic                fault;
    logic [1:0]          retry_count;

    pll_lock_supervisor #(
        .CHANNELS        (CHANNELS),
        .SYNC_STAGES     (SYNC_STAGES),
        .PLL_RST_CYCLES  (PLL_RST_CYCLES),
        .STABLE_CYCLES   (STABLE_CYCLES),
        .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
        .MAX_RETRIES     (MAX_RETRIES)
    ) dut (
        .clk_12m     (clk_12m),
        .rst         (rst),
        .lock_async  (lock_async),
        .pll_resetb  (pll_resetb),
        .locked      (locked),
        .sys_rst     (sys_rst),
        .lost_lock   (lost_lock),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk_12m = ~clk_12m;

    // Number of rising edges seen so far; read on the falling edge.
    int cyc = 0;
    always @(posedge clk_12m) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef enum int {SIG_RESETB, SIG_LOCKED, SIG_SYS_RST, SIG_LOST_LOCK, SIG_FAULT, SIG_RETRY} sig_e;
    typedef struct {
        string tag;
        int    at;
        sig_e  sig;
        int    val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            SIG_RESETB:    return 32'(pll_resetb);
            SIG_LOCKED:    return 32'(locked);
            SIG_SYS_RST:   return 32'(sys_rst);
            SIG_LOST_LOCK: return 32'(lost_lock);
            SIG_FAULT:     return 32'(fault);
            default:       return 32'(retry_count);
        endcase
    endfunction

    task automatic push_exp(input string tag, input int at, input sig_e s, input int val);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.sig = s;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_reset_vals(input string tag, input int at);
        push_exp({tag, "_resetb"},  at, SIG_RESETB,    0);
        push_exp({tag, "_locked"},  at, SIG_LOCKED,    0);
        push_exp({tag, "_sys_rst"}, at, SIG_SYS_RST,   1);
        push_exp({tag, "_lost"},    at, SIG_LOST_LOCK, 0);
        push_exp({tag, "_fault"},   at, SIG_FAULT,     0);
        push_exp({tag, "_retry"},   at, SIG_RETRY,     0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_12m);
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk_12m) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                check(sb[i].tag, sample(sb[i].sig), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, up, lk, run, d, t, w, hold, to;

        rst        = 1'b1;
        lock_async = 2'b00;

        // 1: reset values, release, lock 5 cycles after pll_resetb rises.
        wait_to(1);
        rel = 4;
        up  = rel + PLL_RST_CYCLES;
        lk  = up + 5 + SYNC_STAGES;
        run = lk + QUAL;
        push_reset_vals("por", rel);
        push_exp("s1_resetb_low",   up - 1,  SIG_RESETB,  0);
        push_exp("s1_resetb_rise",  up,      SIG_RESETB,  3);
        push_exp("s1_locked_pre",   lk - 1,  SIG_LOCKED,  0);
        push_exp("s1_locked",       lk,      SIG_LOCKED,  3);
        push_exp("s1_sys_rst_hold", run - 1, SIG_SYS_RST, 1);
        push_exp("s1_sys_rst_fall", run,     SIG_SYS_RST, 0);
        push_exp("s1_retry",        run,     SIG_RETRY,   0);
        push_exp("s1_resetb_run",   run,     SIG_RESETB,  3);
        wait_to(rel);
        rst = 1'b0;
        wait_to(up + 5);
        lock_async = 2'b11;

        // 3: drop lock[0] in RUN; 2: lock[1] glitch in the following WAIT_LOCK.
        d = run + 4;
        t = d + SYNC_STAGES;
        w = t + 1 + PLL_RST_CYCLES;
        push_exp("s3_locked_drop",    t,     SIG_LOCKED,    2);
        push_exp("s3_lost_pre",       t,     SIG_LOST_LOCK, 0);
        push_exp("s3_sys_rst_pre",    t,     SIG_SYS_RST,   0);
        push_exp("s3_lost_pulse",     t + 1, SIG_LOST_LOCK, 1);
        push_exp("s3_sys_rst",        t + 1, SIG_SYS_RST,   1);
        push_exp("s3_resetb_low",     t + 1, SIG_RESETB,    0);
        push_exp("s3_lost_clear",     t + 2, SIG_LOST_LOCK, 0);
        push_exp("s3_resetb_low_end", w - 1, SIG_RESETB,    0);
        push_exp("s3_resetb_rise",    w,     SIG_RESETB,    3);
        push_exp("s2_glitch",         w + 4, SIG_LOCKED,    1);
        push_exp("s2_resync",         w + 6, SIG_LOCKED,    3);
        push_exp("s2_no_early_rel",   w + QUAL, SIG_SYS_RST, 1);
        push_exp("s2_sys_rst_hold",   w + 6 + QUAL - 1, SIG_SYS_RST, 1);
        push_exp("s2_sys_rst_fall",   w + 6 + QUAL,     SIG_SYS_RST, 0);
        wait_to(d);
        lock_async = 2'b10;
        wait_to(d + 1);
        lock_async = 2'b11;
        wait_to(w + 2);
        lock_async = 2'b01;
        wait_to(w + 4);
        lock_async = 2'b11;
        run = w + 6 + QUAL;

        // 5: one timeout (retry 1), then lock[1] drops during HOLD.
        d    = run + 4;
        t    = d + SYNC_STAGES;
        w    = t + 1 + PLL_RST_CYCLES;
        to   = w + TIMEOUT_CYCLES;
        up   = to + PLL_RST_CYCLES;
        lk   = up + SYNC_STAGES;
        hold = lk + STABLE_CYCLES;
        push_exp("s5_lost_pulse",    t + 1,    SIG_LOST_LOCK, 1);
        push_exp("s5_retry_pre",     to - 1,   SIG_RETRY,     0);
        push_exp("s5_retry_inc",     to,       SIG_RETRY,     1);
        push_exp("s5_resetb_to",     to,       SIG_RESETB,    0);
        push_exp("s5_resetb_rise",   up,       SIG_RESETB,    3);
        push_exp("s5_hold_resetb",   hold + 1, SIG_RESETB,    3);
        push_exp("s5_hold_locked",   hold + 1, SIG_LOCKED,    1);
        push_exp("s5_drop_resetb",   hold + 2, SIG_RESETB,    0);
        push_exp("s5_drop_no_lost",  hold + 2, SIG_LOST_LOCK, 0);
        push_exp("s5_drop_no_lost2", hold + 3, SIG_LOST_LOCK, 0);
        push_exp("s5_drop_retry",    hold + 2, SIG_RETRY,     1);
        push_exp("s5_no_run",        hold + RST_HOLD_CYCLES, SIG_SYS_RST, 1);
        wait_to(d);
        lock_async = 2'b00;
        wait_to(up);
        lock_async = 2'b11;
        wait_to(hold - 1);
        lock_async = 2'b01;
        wait_to(hold + 3);
        lock_async = 2'b11;
        w   = hold + 2 + PLL_RST_CYCLES;
        run = w + QUAL;
        push_exp("s5_rebring_resetb", w,       SIG_RESETB,  3);
        push_exp("s5_retry_kept",     run - 1, SIG_RETRY,   1);
        push_exp("s5_sys_rst_hold",   run - 1, SIG_SYS_RST, 1);
        push_exp("s5_sys_rst_fall",   run,     SIG_SYS_RST, 0);
        push_exp("s5_retry_clear",    run,     SIG_RETRY,   0);

        // 6a: rst asserted mid-HOLD, then a normal bring-up.
        d    = run + 4;
        t    = d + SYNC_STAGES;
        w    = t + 1 + PLL_RST_CYCLES;
        hold = w + STABLE_CYCLES;
        rel  = hold + 3;
        up   = rel + PLL_RST_CYCLES;
        run  = up + QUAL;
        push_exp("s6a_lost_pulse",  t + 1,    SIG_LOST_LOCK, 1);
        push_exp("s6a_in_hold",     hold + 1, SIG_SYS_RST,   1);
        push_exp("s6a_hold_resetb", hold + 1, SIG_RESETB,    3);
        push_reset_vals("s6a_rst", hold + 2);
        push_reset_vals("s6a_rst2", hold + 3);
        push_exp("s6a_locked",      rel + SYNC_STAGES, SIG_LOCKED, 3);
        push_exp("s6a_resetb_low",  up - 1,  SIG_RESETB,  0);
        push_exp("s6a_resetb_rise", up,      SIG_RESETB,  3);
        push_exp("s6a_sys_rst_hold", run - 1, SIG_SYS_RST, 1);
        push_exp("s6a_sys_rst_fall", run,    SIG_SYS_RST, 0);
        wait_to(d);
        lock_async = 2'b10;
        wait_to(d + 1);
        lock_async = 2'b11;
        wait_to(hold + 1);
        rst = 1'b1;
        wait_to(rel);
        rst = 1'b0;

        // 4: locks held low -> three timeouts -> FAULT; 6b: rst in FAULT.
        d  = run + 4;
        t  = d + SYNC_STAGES;
        w  = t + 1 + PLL_RST_CYCLES;
        push_exp("s4_lost_pulse", t + 1, SIG_LOST_LOCK, 1);
        push_exp("s4_lost_clear", t + 2, SIG_LOST_LOCK, 0);
        push_exp("s4_resetb_w1",  w,     SIG_RESETB,    3);
        for (int k = 0; k < MAX_RETRIES; k++) begin
            to = w + TIMEOUT_CYCLES;
            push_exp($sformatf("s4_retry_pre%0d", k),  to - 1, SIG_RETRY,  k);
            push_exp($sformatf("s4_retry_inc%0d", k),  to,     SIG_RETRY,  k + 1);
            push_exp($sformatf("s4_resetb_to%0d", k),  to,     SIG_RESETB, 0);
            push_exp($sformatf("s4_fault_pre%0d", k),  to,     SIG_FAULT,  0);
            w = to + PLL_RST_CYCLES;
            push_exp($sformatf("s4_resetb_up%0d", k),  w,      SIG_RESETB, 3);
        end
        to = w + TIMEOUT_CYCLES;
        push_exp("s4_fault_pre",    to - 1,  SIG_FAULT,   0);
        push_exp("s4_fault",        to,      SIG_FAULT,   1);
        push_exp("s4_fault_resetb", to,      SIG_RESETB,  0);
        push_exp("s4_fault_sysrst", to,      SIG_SYS_RST, 1);
        push_exp("s4_fault_retry",  to,      SIG_RETRY,   2);
        push_exp("s4_persist",      to + 26, SIG_FAULT,   1);
        push_exp("s4_persist_rb",   to + 26, SIG_RESETB,  0);
        push_exp("s4_persist_sr",   to + 26, SIG_SYS_RST, 1);
        push_exp("s4_persist_lk",   to + 26, SIG_LOCKED,  3);
        wait_to(d);
        lock_async = 2'b00;
        wait_to(to + 6);
        lock_async = 2'b11;

        rel = to + 33;
        up  = rel + PLL_RST_CYCLES;
        run = up + QUAL;
        push_reset_vals("s6b_rst", rel - 1);
        push_exp("s6b_resetb_low",   up - 1,  SIG_RESETB,  0);
        push_exp("s6b_resetb_rise",  up,      SIG_RESETB,  3);
        push_exp("s6b_sys_rst_hold", run - 1, SIG_SYS_RST, 1);
        push_exp("s6b_sys_rst_fall", run,     SIG_SYS_RST, 0);
        push_exp("s6b_fault_clear",  run,     SIG_FAULT,   0);
        wait_to(rel - 2);
        rst = 1'b1;
        wait_to(rel);
        rst = 1'b0;

        wait_to(run + 4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
